alu_sequencer: RTL and testbench

//  Front-end controller for the Basys3 ALU. Conditions four push-buttons
//  (sync, debounce, rising edge) and latches operand A, operand B and the

---
 rtl/alu_sequencer_pkg.sv | 34 +++
 rtl/alu_sequencer_btn_conditioner.sv | 51 +++++
 rtl/alu_sequencer.sv | 158 +++++++++++++++
 tb/tb_alu_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU front-end: opcode encodings, FSM states and
// an opcode legality check.
package alu_sequencer_pkg;

    localparam int unsigned OPCODE_W = 6;

    localparam logic [OPCODE_W-1:0] OP_ADD = 6'b100000;
    localparam logic [OPCODE_W-1:0] OP_SUB = 6'b100010;
    localparam logic [OPCODE_W-1:0] OP_AND = 6'b100100;
    localparam logic [OPCODE_W-1:0] OP_OR  = 6'b100101;
    localparam logic [OPCODE_W-1:0] OP_XOR = 6'b100110;
    localparam logic [OPCODE_W-1:0] OP_SRA = 6'b000011;
    localparam logic [OPCODE_W-1:0] OP_SRL = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_NOR = 6'b100111;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StExec    = 2'd1,
        StCapture = 2'd2,
        StDone    = 2'd3
    } state_e;

    function automatic logic is_valid_opcode(input logic [OPCODE_W-1:0] op);
        logic valid;
        valid = 1'b0;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_XOR, OP_SRA, OP_SRL, OP_NOR: valid = 1'b1;
            default:                        valid = 1'b0;
        endcase
        return valid;
    endfunction

endpackage

// File: rtl/alu_sequencer_btn_conditioner.sv
// Push-button conditioner: 2-FF synchronizer, stability-counter debouncer and
// a single-cycle pulse on the debounced rising edge.
module alu_sequencer_btn_conditioner #(
    parameter int unsigned NB_DEBOUNCE = 20
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_btn,
    output logic o_pulse
);

    // Debounced level flips on the (2**NB_DEBOUNCE-1)-th consecutive differing sample.
    localparam logic [NB_DEBOUNCE-1:0] CntLast = NB_DEBOUNCE'(2 ** NB_DEBOUNCE - 2);

    logic [1:0]             sync_q;
    logic [NB_DEBOUNCE-1:0] cnt_q, cnt_d;
    logic                   db_q, db_d;
    logic                   db_prev_q;
    logic                   pulse_q;

    always_comb begin
        cnt_d = '0;
        db_d  = db_q;
        if (sync_q[1] != db_q) begin
            if (cnt_q == CntLast) begin
                db_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            pulse_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], i_btn};
            cnt_q     <= cnt_d;
            db_q      <= db_d;
            db_prev_q <= db_q;
            pulse_q   <= db_q & ~db_prev_q;
        end
    end

    assign o_pulse = pulse_q;

endmodule

// File: rtl/alu_sequencer.sv
// Front-end controller for the board ALU: latches operands/opcode from the
// switches on conditioned button presses, sequences execution, captures results.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned NB_DATA     = 8,
    parameter int unsigned NB_OPCODE   = 6,
    parameter int unsigned NB_DEBOUNCE = 20
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [NB_DATA-1:0]   i_sw,
    input  logic                 i_btn_load_a,
    input  logic                 i_btn_load_b,
    input  logic                 i_btn_load_op,
    input  logic                 i_btn_exec,
    output logic [NB_DATA-1:0]   o_alu_op_1,
    output logic [NB_DATA-1:0]   o_alu_op_2,
    output logic [NB_OPCODE-1:0] o_alu_opcode,
    input  logic [NB_DATA-1:0]   i_alu_result,
    input  logic                 i_alu_carry,
    output logic [NB_DATA-1:0]   o_result,
    output logic                 o_carry,
    output logic [2:0]           o_loaded,
    output logic                 o_done,
    output logic                 o_error
);

    logic pulse_a, pulse_b, pulse_op, pulse_exec;

    alu_sequencer_btn_conditioner #(.NB_DEBOUNCE(NB_DEBOUNCE)) u_btn_a (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_load_a),
        .o_pulse (pulse_a)
    );

    alu_sequencer_btn_conditioner #(.NB_DEBOUNCE(NB_DEBOUNCE)) u_btn_b (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_load_b),
        .o_pulse (pulse_b)
    );

    alu_sequencer_btn_conditioner #(.NB_DEBOUNCE(NB_DEBOUNCE)) u_btn_op (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_load_op),
        .o_pulse (pulse_op)
    );

    alu_sequencer_btn_conditioner #(.NB_DEBOUNCE(NB_DEBOUNCE)) u_btn_exec (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_btn   (i_btn_exec),
        .o_pulse (pulse_exec)
    );

    state_e               state_q, state_d;
    logic [NB_DATA-1:0]   op_1_q, op_1_d;
    logic [NB_DATA-1:0]   op_2_q, op_2_d;
    logic [NB_OPCODE-1:0] opcode_q, opcode_d;
    logic [NB_DATA-1:0]   result_q, result_d;
    logic                 carry_q, carry_d;
    logic [2:0]           loaded_q, loaded_d;
    logic                 error_q, error_d;
    logic                 any_load;

    assign any_load = pulse_a | pulse_b | pulse_op;

    always_comb begin
        state_d  = state_q;
        op_1_d   = op_1_q;
        op_2_d   = op_2_q;
        opcode_d = opcode_q;
        result_d = result_q;
        carry_d  = carry_q;
        loaded_d = loaded_q;
        error_d  = error_q;

        if (pulse_a) begin
            op_1_d      = i_sw;
            loaded_d[0] = 1'b1;
        end
        if (pulse_b) begin
            op_2_d      = i_sw;
            loaded_d[1] = 1'b1;
        end
        if (pulse_op) begin
            opcode_d    = i_sw[NB_OPCODE-1:0];
            loaded_d[2] = 1'b1;
        end

        // Any load aborts an in-flight run and swallows a coincident exec.
        if (any_load) begin
            error_d = 1'b0;
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (pulse_exec) begin
                        if (loaded_q == 3'b111 && is_valid_opcode(opcode_q)) begin
                            state_d = StExec;
                        end else begin
                            error_d = 1'b1;
                        end
                    end
                end
                StExec: begin
                    state_d = StCapture;
                end
                StCapture: begin
                    result_d = i_alu_result;
                    carry_d  = (opcode_q == OP_ADD) ? i_alu_carry : 1'b0;
                    state_d  = StDone;
                end
                StDone: begin
                    if (pulse_exec) begin
                        state_d = StExec;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q  <= StIdle;
            op_1_q   <= '0;
            op_2_q   <= '0;
            opcode_q <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            loaded_q <= '0;
            error_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_1_q   <= op_1_d;
            op_2_q   <= op_2_d;
            opcode_q <= opcode_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            loaded_q <= loaded_d;
            error_q  <= error_d;
        end
    end

    assign o_alu_op_1   = op_1_q;
    assign o_alu_op_2   = op_2_q;
    assign o_alu_opcode = opcode_q;
    assign o_result     = result_q;
    assign o_carry      = carry_q;
    assign o_loaded     = loaded_q;
    assign o_done       = (state_q == StDone);
    assign o_error      = error_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer with a short debounce window and a
// stand-in combinational ALU on the alu-side ports.
module tb_alu_sequencer;

    localparam logic [3:0] BtnA  = 4'b0001;
    localparam logic [3:0] BtnB  = 4'b0010;
    localparam logic [3:0] BtnOp = 4'b0100;
    localparam logic [3:0] BtnX  = 4'b1000;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sw;
    logic       btn_a, btn_b, btn_op, btn_exec;
    logic [7:0] alu_op_1, alu_op_2, alu_result, result;
    logic [5:0] alu_opcode;
    logic       alu_carry, carry, done, error;
    logic [2:0] loaded;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    alu_sequencer #(
        .NB_DATA     (8),
        .NB_OPCODE   (6),
        .NB_DEBOUNCE (2)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_sw          (sw),
        .i_btn_load_a  (btn_a),
        .i_btn_load_b  (btn_b),
        .i_btn_load_op (btn_op),
        .i_btn_exec    (btn_exec),
        .o_alu_op_1    (alu_op_1),
        .o_alu_op_2    (alu_op_2),
        .o_alu_opcode  (alu_opcode),
        .i_alu_result  (alu_result),
        .i_alu_carry   (alu_carry),
        .o_result      (result),
        .o_carry       (carry),
        .o_loaded      (loaded),
        .o_done        (done),
        .o_error       (error)
    );

    // Stand-in ALU; carry is forced high on non-ADD ops so masking is visible.
    always_comb begin
        alu_result = 8'h00;
        alu_carry  = 1'b1;
        case (alu_opcode)
            6'b100000: {alu_carry, alu_result} = {1'b0, alu_op_1} + {1'b0, alu_op_2};
            6'b100010: alu_result = alu_op_1 - alu_op_2;
            6'b100100: alu_result = alu_op_1 & alu_op_2;
            6'b100101: alu_result = alu_op_1 | alu_op_2;
            6'b100110: alu_result = alu_op_1 ^ alu_op_2;
            6'b100111: alu_result = ~(alu_op_1 | alu_op_2);
            6'b000011: alu_result = $signed(alu_op_1) >>> alu_op_2;
            6'b000010: alu_result = alu_op_1 >> alu_op_2;
            default:   alu_result = 8'h00;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_btns(input logic [3:0] mask);
        {btn_exec, btn_op, btn_b, btn_a} = mask;
    endtask

    // Hold buttons long enough for one debounced pulse, then release and settle.
    task automatic press(input logic [3:0] mask, input logic [7:0] val);
        @(negedge clk);
        sw = val;
        set_btns(mask);
        tick(10);
        set_btns(4'b0000);
        tick(10);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " op_1"},   32'(alu_op_1),   32'h0);
        check({tag, " op_2"},   32'(alu_op_2),   32'h0);
        check({tag, " opcode"}, 32'(alu_opcode), 32'h0);
        check({tag, " result"}, 32'(result),     32'h0);
        check({tag, " carry"},  32'(carry),      32'h0);
        check({tag, " loaded"}, 32'(loaded),     32'h0);
        check({tag, " done"},   32'(done),       32'h0);
        check({tag, " error"},  32'(error),      32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        sw    = 8'h00;
        set_btns(4'b0000);
        tick(3);
        check_all_zero("reset");
        reset = 1'b0;

        // ADD 05+03 with exec-to-done latency
        press(BtnA, 8'h05);
        press(BtnB, 8'h03);
        press(BtnOp, 8'h20);
        check("loaded all", 32'(loaded), 32'h7);
        check("op_1 load", 32'(alu_op_1), 32'h05);
        check("op_2 load", 32'(alu_op_2), 32'h03);
        check("opcode load", 32'(alu_opcode), 32'h20);
        @(negedge clk);
        btn_exec = 1'b1;
        repeat (8) @(posedge clk);
        @(negedge clk);
        check("done early", 32'(done), 32'h0);
        @(negedge clk);
        check("done at 3", 32'(done), 32'h1);
        check("add result", 32'(result), 32'h08);
        check("add carry", 32'(carry), 32'h0);
        btn_exec = 1'b0;
        tick(10);

        // Reset while in the execute state
        @(negedge clk);
        btn_exec = 1'b1;
        repeat (7) @(posedge clk);
        @(negedge clk);
        reset    = 1'b1;
        btn_exec = 1'b0;
        @(negedge clk);
        check_all_zero("mid reset");
        tick(2);
        reset = 1'b0;

        // ADD with carry out, then SRA with carry masked
        press(BtnA, 8'hF0);
        press(BtnB, 8'h20);
        press(BtnOp, 8'h20);
        press(BtnX, 8'h00);
        check("add2 done", 32'(done), 32'h1);
        check("add2 result", 32'(result), 32'h10);
        check("add2 carry", 32'(carry), 32'h1);
        press(BtnOp, 8'h03);
        check("load clears done", 32'(done), 32'h0);
        check("result held", 32'(result), 32'h10);
        check("carry held", 32'(carry), 32'h1);
        press(BtnB, 8'h02);
        press(BtnX, 8'h00);
        check("sra result", 32'(result), 32'hFC);
        check("sra carry", 32'(carry), 32'h0);

        // Error paths
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        press(BtnA, 8'h11);
        press(BtnB, 8'h22);
        press(BtnX, 8'h00);
        check("missing op error", 32'(error), 32'h1);
        check("missing op done", 32'(done), 32'h0);
        check("missing op loaded", 32'(loaded), 32'h3);
        press(BtnOp, 8'h3F);
        check("load clears error", 32'(error), 32'h0);
        press(BtnX, 8'h00);
        check("bad opcode error", 32'(error), 32'h1);
        check("bad opcode done", 32'(done), 32'h0);

        // Bouncing button must not produce a pulse
        @(negedge clk);
        sw = 8'h77;
        for (int i = 0; i < 10; i++) begin
            btn_a = ~i[0];
            @(negedge clk);
        end
        btn_a = 1'b0;
        tick(15);
        check("bounce op_1", 32'(alu_op_1), 32'h11);
        check("bounce error", 32'(error), 32'h1);
        btn_a = 1'b1;
        tick(10);
        check("hold op_1", 32'(alu_op_1), 32'h77);
        check("hold error", 32'(error), 32'h0);
        sw = 8'h11;
        tick(10);
        check("single pulse", 32'(alu_op_1), 32'h77);
        btn_a = 1'b0;
        tick(10);

        // Load and exec together; then abort via load during execute
        press(BtnOp, 8'h24);
        press(BtnB, 8'h0F);
        press(BtnX, 8'h00);
        check("and result", 32'(result), 32'h07);
        check("and done", 32'(done), 32'h1);
        press(BtnA | BtnX, 8'h09);
        check("load+exec op_1", 32'(alu_op_1), 32'h09);
        check("load+exec done", 32'(done), 32'h0);
        check("load+exec error", 32'(error), 32'h0);
        @(negedge clk);
        sw       = 8'h03;
        btn_exec = 1'b1;
        @(negedge clk);
        btn_b = 1'b1;
        tick(10);
        set_btns(4'b0000);
        tick(10);
        check("abort op_2", 32'(alu_op_2), 32'h03);
        check("abort done", 32'(done), 32'h0);
        check("abort result", 32'(result), 32'h07);
        check("abort error", 32'(error), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
